// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framing transmitter: start bit, WIDTH data bits, then an idle gap,
// each bit held for CLKS_PER_BIT clocks. All outputs are registered.
module serial_frame_tx #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned MSB_FIRST    = 0,
    parameter int unsigned GAP_BITS     = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_d,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned CycW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitMax = (WIDTH > GAP_BITS) ? WIDTH : GAP_BITS;
    localparam int unsigned BitW   = (BitMax > 1) ? $clog2(BitMax) : 1;

    localparam logic [CycW-1:0] CycLast  = CycW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(WIDTH - 1);
    localparam logic [BitW-1:0] GapLast  = BitW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [1:0] {StIdle, StStart, StData, StGap} state_e;

    state_e           state_q, state_d;
    logic [CycW-1:0]  cyc_q, cyc_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             d_q, d_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cyc_last;
    logic [WIDTH-1:0] shreg_adv;

    assign cyc_last  = (cyc_q == CycLast);
    assign shreg_adv = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_q[WIDTH-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            d_q     <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            d_q     <= d_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Transfers are gated by the registered ready so the first post-reset edge never captures.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid && ready_q) begin
                    state_d = StStart;
                    shreg_d = i_data;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (cyc_last) begin
                    state_d = StData;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StData: begin
                if (cyc_last) begin
                    cyc_d   = '0;
                    shreg_d = shreg_adv;
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
                        state_d = (GAP_BITS > 0) ? StGap : StIdle;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StGap: begin
                if (cyc_last) begin
                    cyc_d = '0;
                    if (bit_q == GapLast) begin
                        bit_d   = '0;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from next-state values so the registers track the state exactly.
    always_comb begin
        d_d    = 1'b0;
        done_d = 1'b0;
        unique case (state_d)
            StStart: d_d = 1'b1;
            StData: begin
                d_d    = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
                done_d = (bit_d == DataLast) && (cyc_d == CycLast);
            end
            default: d_d = 1'b0;
        endcase
        busy_d  = (state_d != StIdle);
        ready_d = (state_d == StIdle);
    end

    assign o_d     = d_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule
